// File: rtl/fxu_reservation_station.sv
// rtl/fxu_reservation_station.sv - Collapsing-queue reservation station in front of the FXU
// Slot 0 is always the oldest; issue picks the lowest ready slot from registered state.
module fxu_reservation_station #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 16,
  localparam int CNT_W = $clog2(DEPTH+1),
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              disp_valid,
  output logic              disp_ready,
  input  logic [3:0]        disp_opcode,
  input  logic [TAG_W-1:0]  disp_rob_index,
  input  logic              disp_a_rdy,
  input  logic [TAG_W-1:0]  disp_a_tag,
  input  logic [DATA_W-1:0] disp_a_val,
  input  logic              disp_b_rdy,
  input  logic [TAG_W-1:0]  disp_b_tag,
  input  logic [DATA_W-1:0] disp_b_val,
  input  logic [7:0]        disp_i,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_value,
  output logic              iss_valid,
  output logic [3:0]        iss_opcode,
  output logic [TAG_W-1:0]  iss_index,
  output logic [DATA_W-1:0] iss_va,
  output logic [DATA_W-1:0] iss_vb,
  output logic [7:0]        iss_i,
  output logic [CNT_W-1:0]  count
);

  typedef struct packed {
    logic              valid;
    logic [3:0]        opcode;
    logic [TAG_W-1:0]  rob;
    logic              a_rdy;
    logic [TAG_W-1:0]  a_tag;
    logic [DATA_W-1:0] a_val;
    logic              b_rdy;
    logic [TAG_W-1:0]  b_tag;
    logic [DATA_W-1:0] b_val;
    logic [7:0]        imm;
  } slot_t;

  slot_t            slot_q [DEPTH];
  slot_t            slot_d [DEPTH];
  slot_t            woke   [DEPTH];
  slot_t            shifted[DEPTH];
  slot_t            new_e;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] ins_pos;
  logic [IDX_W-1:0] iss_sel;
  logic             any_rdy;
  logic             disp_fire;

  always_comb begin
    any_rdy = 1'b0;
    iss_sel = '0;
    for (int k = DEPTH-1; k >= 0; k--) begin
      if (slot_q[k].valid && slot_q[k].a_rdy && slot_q[k].b_rdy) begin
        any_rdy = 1'b1;
        iss_sel = k[IDX_W-1:0];
      end
    end
  end

  assign iss_valid  = any_rdy & ~flush;
  assign disp_ready = (count_q != CNT_W'(DEPTH));
  assign disp_fire  = disp_valid & disp_ready & ~flush;
  assign count      = count_q;

  assign iss_opcode = slot_q[iss_sel].opcode;
  assign iss_index  = slot_q[iss_sel].rob;
  assign iss_va     = slot_q[iss_sel].a_val;
  assign iss_vb     = slot_q[iss_sel].b_val;
  assign iss_i      = slot_q[iss_sel].imm;

  // A dispatching operand whose producer broadcasts this same cycle is stored already captured.
  always_comb begin
    new_e        = '0;
    new_e.valid  = 1'b1;
    new_e.opcode = disp_opcode;
    new_e.rob    = disp_rob_index;
    new_e.a_tag  = disp_a_tag;
    new_e.b_tag  = disp_b_tag;
    new_e.imm    = disp_i;
    new_e.a_rdy  = disp_a_rdy | (cdb_valid && (cdb_tag == disp_a_tag));
    new_e.a_val  = disp_a_rdy ? disp_a_val : cdb_value;
    new_e.b_rdy  = disp_b_rdy | (cdb_valid && (cdb_tag == disp_b_tag));
    new_e.b_val  = disp_b_rdy ? disp_b_val : cdb_value;
  end

  // Wakeup is applied before the collapse so a capture survives the shift.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      woke[k] = slot_q[k];
      if (cdb_valid && slot_q[k].valid && !slot_q[k].a_rdy && (slot_q[k].a_tag == cdb_tag)) begin
        woke[k].a_rdy = 1'b1;
        woke[k].a_val = cdb_value;
      end
      if (cdb_valid && slot_q[k].valid && !slot_q[k].b_rdy && (slot_q[k].b_tag == cdb_tag)) begin
        woke[k].b_rdy = 1'b1;
        woke[k].b_val = cdb_value;
      end
    end
    for (int k = 0; k < DEPTH-1; k++) begin
      shifted[k] = (iss_valid && (k >= int'(iss_sel))) ? woke[k+1] : woke[k];
    end
    shifted[DEPTH-1] = iss_valid ? '0 : woke[DEPTH-1];
  end

  always_comb begin
    ins_pos = count_q - CNT_W'(iss_valid);
    count_d = count_q + CNT_W'(disp_fire) - CNT_W'(iss_valid);
    for (int k = 0; k < DEPTH; k++) begin
      slot_d[k] = (disp_fire && (k == int'(ins_pos))) ? new_e : shifted[k];
    end
    if (flush) begin
      count_d = '0;
      for (int k = 0; k < DEPTH; k++) slot_d[k].valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      for (int k = 0; k < DEPTH; k++) slot_q[k] <= '0;
    end else begin
      count_q <= count_d;
      for (int k = 0; k < DEPTH; k++) slot_q[k] <= slot_d[k];
    end
  end

endmodule

// File: tb/tb_fxu_reservation_station.sv
// tb/tb_fxu_reservation_station.sv - Bench for fxu_reservation_station
// Directed vector table, reset corner, and random traffic against a queue-based model.
module tb_fxu_reservation_station;

  localparam int DEPTH  = 4;
  localparam int TAG_W  = 4;
  localparam int DATA_W = 16;
  localparam int CNT_W  = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              disp_valid = 1'b0;
  logic              disp_ready;
  logic [3:0]        disp_opcode = '0;
  logic [TAG_W-1:0]  disp_rob_index = '0;
  logic              disp_a_rdy = 1'b0;
  logic [TAG_W-1:0]  disp_a_tag = '0;
  logic [DATA_W-1:0] disp_a_val = '0;
  logic              disp_b_rdy = 1'b0;
  logic [TAG_W-1:0]  disp_b_tag = '0;
  logic [DATA_W-1:0] disp_b_val = '0;
  logic [7:0]        disp_i = '0;
  logic              cdb_valid = 1'b0;
  logic [TAG_W-1:0]  cdb_tag = '0;
  logic [DATA_W-1:0] cdb_value = '0;
  logic              iss_valid;
  logic [3:0]        iss_opcode;
  logic [TAG_W-1:0]  iss_index;
  logic [DATA_W-1:0] iss_va;
  logic [DATA_W-1:0] iss_vb;
  logic [7:0]        iss_i;
  logic [CNT_W-1:0]  count;

  always #5 clk = ~clk;

  fxu_reservation_station #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_opcode(disp_opcode),
    .disp_rob_index(disp_rob_index),
    .disp_a_rdy(disp_a_rdy), .disp_a_tag(disp_a_tag), .disp_a_val(disp_a_val),
    .disp_b_rdy(disp_b_rdy), .disp_b_tag(disp_b_tag), .disp_b_val(disp_b_val),
    .disp_i(disp_i), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .iss_valid(iss_valid), .iss_opcode(iss_opcode), .iss_index(iss_index),
    .iss_va(iss_va), .iss_vb(iss_vb), .iss_i(iss_i), .count(count)
  );

  typedef struct {
    bit fl; bit dv; int op; int rob;
    bit ar; int at; int av; bit br; int bt; int bv; int imm;
    bit cv; int ct; int cval;
  } in_t;

  typedef struct {
    in_t in;
    bit eiv; int eidx; int eva; int evb; int ecnt; bit edr;
  } row_t;

  typedef struct {
    int op; int rob; bit a_rdy; int a_tag; int a_val; bit b_rdy; int b_tag; int b_val; int imm;
  } m_ent_t;

  m_ent_t m_q[$];
  int     n_checks = 0;
  int     n_fail = 0;
  row_t   tbl[34];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic row_t mk(bit fl, bit dv, int op, int rob, bit ar, int at, int av, bit br,
                              int bv, int imm, bit cv, int ct, int cval,
                              bit eiv, int eidx, int eva, int evb, int ecnt, bit edr);
    row_t r;
    r.in = '{fl, dv, op, rob, ar, at, av, br, 0, bv, imm, cv, ct, cval};
    r.eiv = eiv; r.eidx = eidx; r.eva = eva; r.evb = evb; r.ecnt = ecnt; r.edr = edr;
    return r;
  endfunction

  function automatic row_t idle(bit eiv, int eidx, int eva, int evb, int ecnt, bit edr);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, eiv, eidx, eva, evb, ecnt, edr);
  endfunction

  task automatic drive(input in_t v);
    flush          = v.fl;
    disp_valid     = v.dv;
    disp_opcode    = 4'(v.op);
    disp_rob_index = TAG_W'(v.rob);
    disp_a_rdy     = v.ar;
    disp_a_tag     = TAG_W'(v.at);
    disp_a_val     = DATA_W'(v.av);
    disp_b_rdy     = v.br;
    disp_b_tag     = TAG_W'(v.bt);
    disp_b_val     = DATA_W'(v.bv);
    disp_i         = 8'(v.imm);
    cdb_valid      = v.cv;
    cdb_tag        = TAG_W'(v.ct);
    cdb_value      = DATA_W'(v.cval);
  endtask

  // One cycle: drive, check outputs against the model, then advance the model past the edge.
  task automatic step(input in_t v);
    int     sel;
    bit     exp_iv, exp_dr;
    m_ent_t e;
    @(negedge clk);
    drive(v);
    #1;
    exp_dr = (m_q.size() != DEPTH);
    sel = -1;
    foreach (m_q[j]) if (sel < 0 && m_q[j].a_rdy && m_q[j].b_rdy) sel = j;
    exp_iv = (sel >= 0) && !v.fl;
    chk("count", int'(count), m_q.size());
    chk("disp_ready", int'(disp_ready), int'(exp_dr));
    chk("iss_valid", int'(iss_valid), int'(exp_iv));
    if (exp_iv && iss_valid) begin
      chk("iss_opcode", int'(iss_opcode), m_q[sel].op);
      chk("iss_index", int'(iss_index), m_q[sel].rob);
      chk("iss_va", int'(iss_va), m_q[sel].a_val);
      chk("iss_vb", int'(iss_vb), m_q[sel].b_val);
      chk("iss_i", int'(iss_i), m_q[sel].imm);
    end
    if (v.fl) begin
      m_q.delete();
    end else begin
      if (v.cv) begin
        foreach (m_q[j]) begin
          if (!m_q[j].a_rdy && m_q[j].a_tag == v.ct) begin m_q[j].a_rdy = 1; m_q[j].a_val = v.cval; end
          if (!m_q[j].b_rdy && m_q[j].b_tag == v.ct) begin m_q[j].b_rdy = 1; m_q[j].b_val = v.cval; end
        end
      end
      if (exp_iv) m_q.delete(sel);
      if (v.dv && exp_dr) begin
        e.op = v.op; e.rob = v.rob; e.imm = v.imm; e.a_tag = v.at; e.b_tag = v.bt;
        e.a_rdy = v.ar || (v.cv && v.ct == v.at);
        e.a_val = v.ar ? v.av : v.cval;
        e.b_rdy = v.br || (v.cv && v.ct == v.bt);
        e.b_val = v.br ? v.bv : v.cval;
        m_q.push_back(e);
      end
    end
  endtask

  initial begin
    in_t r;

    tbl[0]  = mk(0,1,0,3,1,0,5,1,7,0, 0,0,0, 0,0,0,0,0,1);
    tbl[1]  = idle(1,3,5,7,1,1);
    tbl[2]  = idle(0,0,0,0,0,1);
    tbl[3]  = mk(0,1,1,1,0,6,0,1,2,0, 0,0,0, 0,0,0,0,0,1);
    tbl[4]  = idle(0,0,0,0,1,1);
    tbl[5]  = mk(0,0,0,0,0,0,0,0,0,0, 1,6,'h1234, 0,0,0,0,1,1);
    tbl[6]  = idle(1,1,'h1234,2,1,1);
    tbl[7]  = idle(0,0,0,0,0,1);
    tbl[8]  = mk(0,1,2,4,0,9,0,1,'h14,0, 0,0,0, 0,0,0,0,0,1);
    tbl[9]  = mk(0,1,2,5,0,9,0,1,'h15,0, 0,0,0, 0,0,0,0,1,1);
    tbl[10] = mk(0,1,2,6,0,9,0,1,'h16,0, 0,0,0, 0,0,0,0,2,1);
    tbl[11] = mk(0,1,2,7,0,9,0,1,'h17,0, 0,0,0, 0,0,0,0,3,1);
    tbl[12] = mk(0,1,2,8,0,9,0,1,'h18,0, 0,0,0, 0,0,0,0,4,0);
    tbl[13] = mk(0,0,0,0,0,0,0,0,0,0, 1,9,'h99, 0,0,0,0,4,0);
    tbl[14] = idle(1,4,'h99,'h14,4,0);
    tbl[15] = idle(1,5,'h99,'h15,3,1);
    tbl[16] = idle(1,6,'h99,'h16,2,1);
    tbl[17] = idle(1,7,'h99,'h17,1,1);
    tbl[18] = idle(0,0,0,0,0,1);
    tbl[19] = mk(0,1,0,10,0,12,0,1,0,0, 0,0,0, 0,0,0,0,0,1);
    tbl[20] = mk(0,1,0,11,1,0,'h11,1,0,0, 0,0,0, 0,0,0,0,1,1);
    tbl[21] = mk(0,0,0,0,0,0,0,0,0,0, 1,12,'hAA, 1,11,'h11,0,2,1);
    tbl[22] = mk(0,1,0,13,1,0,'h13,1,0,0, 0,0,0, 1,10,'hAA,0,1,1);
    tbl[23] = idle(1,13,'h13,0,1,1);
    tbl[24] = idle(0,0,0,0,0,1);
    tbl[25] = mk(0,1,3,2,1,0,0,1,0,'h80, 1,2,'h5555, 0,0,0,0,0,1);
    tbl[26] = mk(0,1,0,6,0,5,0,1,1,0, 1,5,'hBEEF, 1,2,0,0,1,1);
    tbl[27] = idle(1,6,'hBEEF,1,1,1);
    tbl[28] = idle(0,0,0,0,0,1);
    tbl[29] = mk(0,1,0,1,0,15,0,1,0,0, 0,0,0, 0,0,0,0,0,1);
    tbl[30] = mk(0,1,0,2,0,15,0,1,0,0, 0,0,0, 0,0,0,0,1,1);
    tbl[31] = mk(0,1,0,3,1,0,3,1,0,0, 0,0,0, 0,0,0,0,2,1);
    tbl[32] = mk(1,1,0,4,1,0,4,1,0,0, 1,15,'h7777, 0,0,0,0,3,1);
    tbl[33] = idle(0,0,0,0,0,1);

    repeat (2) @(negedge clk);
    #1;
    chk("reset_count", int'(count), 0);
    chk("reset_disp_ready", int'(disp_ready), 1);
    chk("reset_iss_valid", int'(iss_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[n]) begin
      step(tbl[n].in);
      chk($sformatf("vec%0d_iss_valid", n), int'(iss_valid), int'(tbl[n].eiv));
      chk($sformatf("vec%0d_count", n), int'(count), tbl[n].ecnt);
      chk($sformatf("vec%0d_disp_ready", n), int'(disp_ready), int'(tbl[n].edr));
      if (tbl[n].eiv) begin
        chk($sformatf("vec%0d_iss_index", n), int'(iss_index), tbl[n].eidx);
        chk($sformatf("vec%0d_iss_va", n), int'(iss_va), tbl[n].eva);
        chk($sformatf("vec%0d_iss_vb", n), int'(iss_vb), tbl[n].evb);
      end
    end

    // Asynchronous reset between clock edges with entries held.
    step(mk(0,1,0,1,0,14,0,1,0,0, 0,0,0, 0,0,0,0,0,1).in);
    step(mk(0,1,0,2,0,14,0,1,0,0, 0,0,0, 0,0,0,0,0,1).in);
    @(negedge clk);
    drive(idle(0,0,0,0,0,1).in);
    #1;
    chk("pre_reset_count", int'(count), 2);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_count", int'(count), 0);
    chk("async_reset_disp_ready", int'(disp_ready), 1);
    chk("async_reset_iss_valid", int'(iss_valid), 0);
    m_q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    for (int c = 0; c < 800; c++) begin
      r.fl   = ($urandom_range(0, 99) < 3);
      r.dv   = ($urandom_range(0, 99) < 60);
      r.op   = $urandom_range(0, 4);
      r.rob  = $urandom_range(0, 15);
      r.ar   = $urandom_range(0, 1);
      r.at   = $urandom_range(0, 7);
      r.av   = $urandom_range(0, 16'hFFFF);
      r.br   = ($urandom_range(0, 99) < 65);
      r.bt   = $urandom_range(0, 7);
      r.bv   = $urandom_range(0, 16'hFFFF);
      r.imm  = $urandom_range(0, 255);
      r.cv   = ($urandom_range(0, 99) < 40);
      r.ct   = $urandom_range(0, 7);
      r.cval = $urandom_range(0, 16'hFFFF);
      step(r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fxu_reservation_station.md
Name: fxu_reservation_station

Overview:
- In-order-allocated, out-of-order-issue reservation station in front of the fixed-point unit (add/sub/mov/movl/movh).
- Holds dispatched ops until both source operands are valid. Captures missing operands by snooping the common data bus (CDB).
- Selects the oldest ready entry and issues at most one op per cycle on the FXU input interface. Flush empties it.

Parameters:
- DEPTH, 4, number of entries (2..8).
- TAG_W, 4, ROB tag / index width.
- DATA_W, 16, operand width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline flush, drop all entries.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  entry available (count < DEPTH).
- disp_opcode  in  4  FXU opcode.
- disp_rob_index  in  TAG_W  destination ROB index.
- disp_a_rdy  in  1  operand A value present.
- disp_a_tag  in  TAG_W  producer tag of A when not present.
- disp_a_val  in  DATA_W  A value when present.
- disp_b_rdy, disp_b_tag, disp_b_val  in  1/TAG_W/DATA_W  same for B.
- disp_i  in  8  immediate.
- cdb_valid  in  1  result broadcast.
- cdb_tag  in  TAG_W  broadcasting ROB index.
- cdb_value  in  DATA_W  broadcast value.
- iss_valid  out  1  op issued to FXU this cycle.
- iss_opcode  out  4; iss_index  out  TAG_W; iss_va, iss_vb  out  DATA_W; iss_i  out  8  issued op fields.
- count  out  $clog2(DEPTH+1)  occupied entries.

Behaviour:
- Storage is a collapsing queue. Slot 0 is always the oldest. Each slot holds: valid, opcode, rob_index, a_rdy/a_tag/a_val, b_rdy/b_tag/b_val, i.
- Reset (rst_n=0, async): all slot valids 0, count=0. Hence iss_valid=0 and disp_ready=1. Data fields are don't-care.
- Unused operands: dispatch marks them ready (movl: A and B; mov/movh: B). The station only obeys the rdy flags.
- Dispatch: accepted at a posedge when disp_valid & disp_ready & ~flush. It is written to the first free slot after any same-cycle collapse.
- disp_ready = (count != DEPTH). It does not account for a same-cycle issue (conservative).
- Dispatch-time bypass: if cdb_valid and cdb_tag equals a not-ready disp tag in the same cycle, the entry is stored with that operand ready and holding cdb_value.
- Wakeup: on cdb_valid, every valid slot whose not-ready operand tag matches captures cdb_value and sets rdy at that posedge. Both A and B may match the same broadcast.
- A slot is ready when valid & a_rdy & b_rdy. Readiness is from registered state only, so wakeup-to-issue is at least 1 cycle. A dispatched entry can issue no earlier than the cycle after acceptance.
- Issue is combinational from registered state. iss_valid = (any ready slot) & ~flush. The lowest-numbered ready slot drives the iss_* fields. When iss_valid=0, the iss_* data fields are don't-care.
- At the posedge with iss_valid=1, the issued slot is removed. Slots above it shift down by one with their fields, and any same-edge CDB capture is preserved through the shift.
- Simultaneous issue + dispatch: count unchanged, and the new entry lands in slot count-1. A full station issuing and receiving disp_valid does not accept (disp_ready=0).
- Flush: at the posedge with flush=1, all valids clear and count=0. Dispatch and CDB in that cycle are ignored, and iss_valid=0 in that cycle.
- Reset mid-operation clears immediately regardless of clock.
- No arithmetic is done here. count increments/decrements by at most 1 per cycle and never wraps.

Test Plan:
- Reset, then dispatch add rob=3 with A=0x0005 and B=0x0007 both ready -> next cycle iss_valid=1, iss_opcode=0, iss_index=3, iss_va=5, iss_vb=7. count goes 1 then 0.
- Dispatch sub rob=1 with A waiting on tag 6; two cycles later cdb_valid tag=6 value=0x1234 -> iss_valid the following cycle with iss_va=0x1234. No issue earlier.
- Fill DEPTH=4 entries all waiting on tag 9 -> disp_ready=0 and count=4. Then cdb tag=9 -> four consecutive issues in dispatch order; disp_ready returns to 1 after the first issue edge.
- Oldest-first: slot0 waiting and slot1 ready -> slot1 issues. When slot0 wakes, it issues next, and a younger ready entry dispatched later issues after it.
- Dispatch movl rob=2 i=0x80 while cdb tag=2 simultaneously broadcasts; then same-cycle dispatch with A tag=5 and cdb tag=5 value=0xBEEF -> entry issues next cycle with iss_va=0xBEEF (bypass).
- With 3 entries held, assert flush together with disp_valid -> count=0, iss_valid=0 that cycle, dispatch dropped. Assert rst_n=0 between clock edges -> count=0 immediately.
